tap_ram_axil_bridge: RTL and testbench
======================================

# tap_ram_axil_bridge

AXI4-Lite slave that gives the host (Caravel management core, via the user wishbone-to-AXI path) read/write access to a dual-port tap/data BRAM. It sits between the AXI-Lite bus and the BRAM's write port (`we`/`waddr`/`wdi`) and read port (`re`/`raddr`/`rdo`). It converts byte addresses to word indices, sequences the BRAM's one-cycle read latency, and returns AXI responses.

## Interface
- `ADDR_WIDTH`, 12: AXI address width; also the width of the BRAM word-index buses.
- `SIZE`, 11: number of BRAM words.
- `BIT_WIDTH`, 32: data width.
- `BASE_ADDR`, 12'h020: byte address of word 0.
- `axis_clk`  in  1  single clock; also clocks the BRAM.
- `axis_rst_n`  in  1  asynchronous, active-low reset.
- `awaddr`  in  ADDR_WIDTH; `awvalid` in 1; `awready` out 1: write-address channel.
- `wdata`  in  BIT_WIDTH; `wstrb` in 4; `wvalid` in 1; `wready` out 1: write-data channel.
- `bresp`  out  2; `bvalid` out 1; `bready` in 1: write-response channel.
- `araddr`  in  ADDR_WIDTH; `arvalid` in 1; `arready` out 1: read-address channel.
- `rdata`  out  BIT_WIDTH; `rresp` out 2; `rvalid` out 1; `rready` in 1: read-data channel.
- `ram_we`  out  1; `ram_waddr` out ADDR_WIDTH; `ram_wdi` out BIT_WIDTH: BRAM write port.
- `ram_re`  out  1; `ram_raddr` out ADDR_WIDTH; `ram_rdo` in BIT_WIDTH: BRAM read port. `ram_rdo` is registered in the BRAM and is valid the cycle after an edge that samples `ram_re`=1.

## Operation
- Word index = (addr − BASE_ADDR) >> 2.
- An address is in range iff BASE_ADDR ≤ addr < BASE_ADDR + 4·SIZE. Address bits [1:0] are ignored.
- Write FSM: W_IDLE → W_MEM → W_RESP → W_IDLE.
  - W_IDLE: `awready`=1 until AW is latched; `wready`=1 until W is latched. AW and W are accepted independently, in either order or on the same edge.
  - Once both are latched, move to W_MEM.
  - W_MEM (1 cycle): `ram_we`=1 only if the address is in range and `wstrb`==4'hF. `ram_waddr` = index; `ram_wdi` = latched `wdata`.
  - W_RESP: `bvalid`=1 until `bready`. `bresp`=2'b00 (OKAY) if the write was performed, otherwise 2'b10 (SLVERR).
- Read FSM: R_IDLE → R_MEM → R_RESP → R_IDLE.
  - R_IDLE: `arready`=1.
  - R_MEM (1 cycle): `ram_re`=1 with `ram_raddr` = index, only if in range.
  - R_RESP: `rvalid`=1 until `rready`. `rdata` = `ram_rdo` (stable because `ram_re`=0) if in range, else 0. `rresp` = OKAY or SLVERR accordingly.
- The read and write FSMs run concurrently; the BRAM ports are independent.
- Read and write of the same word in the same cycle: the read returns the old data.
- Outputs never depend combinationally on `valid`/`ready` inputs.

## Timing
- Reset values: `awready`=0, `wready`=0, `arready`=0, `bvalid`=0, `rvalid`=0, `bresp`=0, `rresp`=0, `rdata`=0, `ram_we`=0, `ram_re`=0, `ram_waddr`=0, `ram_raddr`=0, `ram_wdi`=0.
- Ready signals assert on the first edge after reset deassertion.
- Write: edge E0 completes the second of AW/W. `ram_we` is high in cycle E0→E1. `bvalid` rises after E1. This is a 2-cycle minimum to B. Best case is 3 cycles per write.
- Read: AR handshake at E0. `ram_re` is high in E0→E1. `rvalid` rises after E1. This is a 2-cycle minimum. Back-to-back throughput is one read per 3 cycles when `rready` is held high.
- `awready`/`wready` stay low while a write is in W_MEM/W_RESP. `arready` stays low in R_MEM/R_RESP.
- Reset asserted mid-transaction: immediate return to idle and reset values. Latched AW/W/AR are discarded and no `ram_we` pulse is issued.

## Configuration
- `TAP_RAM_READBACK_EN` defined: reads behave as above.
- `TAP_RAM_READBACK_EN` undefined:
  - AR is still accepted and answered with the same 2-cycle timing.
  - `ram_re` is tied 0; `rdata`=0 and `rresp`=SLVERR for every address.
  - The write path is unchanged.

## Test plan
- Write 0x0000_1234 to 0x020, then 0xDEAD_BEEF to 0x048 (index 10), then read both back → `ram_we` pulses with indices 0 and 10. Reads return the written values with OKAY, `rvalid` 2 cycles after AR.
- W presented 3 cycles before AW (and the reverse), data 0xA5A5_A5A5 at 0x024 → single `ram_we` at index 1 the cycle after the AW handshake, then OKAY.
- Write to 0x04C (index 11) and 0x01C; separately, write with `wstrb`=4'h3 → no `ram_we`, `bresp`=2'b10. Read 0x04C → `rdata`=0, `rresp`=2'b10.
- `bready`/`rready` held low for 5 cycles → `bvalid`/`rvalid` and the data/resp fields stay stable; no new AW/W/AR is accepted until the handshake completes.
- Concurrent write 0x1111_1111 and read to index 2 (old value 0x2222_2222) on the same edge → read returns 0x2222_2222; a subsequent read returns 0x1111_1111.
- Assert `axis_rst_n` while in W_MEM-pending (AW latched, W not yet latched) → all outputs return to reset values and no `ram_we` occurs. A later full write works normally.

Source files
------------

// File: rtl/tap_ram_axil_bridge.sv
// tap_ram_axil_bridge
// AXI4-Lite slave giving the host read/write access to a dual-port tap/data
// BRAM. Byte addresses are converted to word indices relative to BASE_ADDR.
// The bridge also sequences the BRAM's one-cycle registered read and returns
// OKAY/SLVERR responses.
//
// Ports:
//   axis_clk, axis_rst_n          clock, asynchronous active-low reset
//   aw*/w*/b*                     AXI-Lite write address/data/response
//   ar*/r*                        AXI-Lite read address/data
//   ram_we/ram_waddr/ram_wdi      BRAM write port
//   ram_re/ram_raddr/ram_rdo      BRAM read port (ram_rdo registered in BRAM)
//
// Build option: TAP_RAM_READBACK_EN
//   defined   - reads return BRAM contents.
//   undefined - reads are still handshaked with normal timing, but ram_re
//               stays low and every read answers rdata=0 with SLVERR.
module tap_ram_axil_bridge #(
  parameter int ADDR_WIDTH = 12,
  parameter int SIZE       = 11,
  parameter int BIT_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 12'h020
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst_n,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [BIT_WIDTH-1:0]  wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [BIT_WIDTH-1:0]  rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [BIT_WIDTH-1:0]  ram_wdi,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [BIT_WIDTH-1:0]  ram_rdo
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_MEM  = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_MEM  = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // One bit wider than the bus so the end bound cannot wrap.
  localparam logic [ADDR_WIDTH:0] ADDR_END =
    (ADDR_WIDTH+1)'(BASE_ADDR) + (ADDR_WIDTH+1)'(4 * SIZE);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < ADDR_END);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return (a - BASE_ADDR) >> 2;
  endfunction

  logic [1:0]            w_state_q, w_state_d;
  logic                  aw_got_q, aw_got_d;
  logic                  w_got_q, w_got_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [BIT_WIDTH-1:0]  wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_waddr_q, ram_waddr_d;
  logic [BIT_WIDTH-1:0]  ram_wdi_q, ram_wdi_d;

  logic [1:0]            r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rd_ok_q, rd_ok_d;
  logic                  ram_re_q, ram_re_d;
  logic [ADDR_WIDTH-1:0] ram_raddr_q, ram_raddr_d;
  logic                  ar_ok;

`ifdef TAP_RAM_READBACK_EN
  assign ar_ok = in_range(araddr);
`else
  assign ar_ok = 1'b0;
`endif

  always_comb begin
    w_state_d   = w_state_q;
    aw_got_d    = aw_got_q;
    w_got_d     = w_got_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    ram_we_d    = 1'b0;
    ram_waddr_d = ram_waddr_q;
    ram_wdi_d   = ram_wdi_q;
    case (w_state_q)
      W_IDLE: begin
        // Each ready stays up until its own channel has been captured.
        if (awvalid && awready_q) begin
          aw_got_d  = 1'b1;
          awaddr_d  = awaddr;
          awready_d = 1'b0;
        end else begin
          awready_d = !aw_got_q;
        end
        if (wvalid && wready_q) begin
          w_got_d  = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
          wready_d = 1'b0;
        end else begin
          wready_d = !w_got_q;
        end
        // Use the _d values so a same-edge completion launches immediately.
        if (aw_got_d && w_got_d) begin
          w_state_d   = W_MEM;
          ram_we_d    = in_range(awaddr_d) && (wstrb_d == 4'hF);
          ram_waddr_d = word_idx(awaddr_d);
          ram_wdi_d   = wdata_d;
          aw_got_d    = 1'b0;
          w_got_d     = 1'b0;
          awready_d   = 1'b0;
          wready_d    = 1'b0;
        end
      end
      W_MEM: begin
        // ram_we_q doubles as the "write performed" flag.
        w_state_d = W_RESP;
        bvalid_d  = 1'b1;
        bresp_d   = ram_we_q ? RESP_OKAY : RESP_SLVERR;
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d   = r_state_q;
    arready_d   = arready_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rd_ok_d     = rd_ok_q;
    ram_re_d    = 1'b0;
    ram_raddr_d = ram_raddr_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          r_state_d   = R_MEM;
          arready_d   = 1'b0;
          rd_ok_d     = ar_ok;
          ram_re_d    = ar_ok;
          ram_raddr_d = word_idx(araddr);
        end
      end
      R_MEM: begin
        r_state_d = R_RESP;
        rvalid_d  = 1'b1;
        rresp_d   = rd_ok_q ? RESP_OKAY : RESP_SLVERR;
      end
      R_RESP: begin
        if (rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          rresp_d   = RESP_OKAY;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      w_state_q   <= W_IDLE;
      aw_got_q    <= 1'b0;
      w_got_q     <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdi_q   <= '0;
      r_state_q   <= R_IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rd_ok_q     <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_raddr_q <= '0;
    end else begin
      w_state_q   <= w_state_d;
      aw_got_q    <= aw_got_d;
      w_got_q     <= w_got_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      ram_we_q    <= ram_we_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdi_q   <= ram_wdi_d;
      r_state_q   <= r_state_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rd_ok_q     <= rd_ok_d;
      ram_re_q    <= ram_re_d;
      ram_raddr_q <= ram_raddr_d;
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign ram_we    = ram_we_q;
  assign ram_waddr = ram_waddr_q;
  assign ram_wdi   = ram_wdi_q;
  assign arready   = arready_q;
  assign rvalid    = rvalid_q;
  assign rresp     = rresp_q;
  assign ram_re    = ram_re_q;
  assign ram_raddr = ram_raddr_q;
  // BRAM output is registered and ram_re is low throughout R_RESP, so the
  // data presented here holds steady for the whole response.
  assign rdata     = (rvalid_q && rd_ok_q) ? ram_rdo : '0;

endmodule

// File: tb/tb_tap_ram_axil_bridge.sv
module tb_tap_ram_axil_bridge;

`ifdef TAP_RAM_READBACK_EN
  localparam logic RB = 1'b1;
`else
  localparam logic RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [11:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        ram_we;
  logic [11:0] ram_waddr;
  logic [31:0] ram_wdi;
  logic        ram_re;
  logic [11:0] ram_raddr;
  logic [31:0] ram_rdo = '0;

  int checks = 0;
  int errors = 0;
  int we_count = 0;

  logic [31:0] mem [0:4095];

  tap_ram_axil_bridge dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdi(ram_wdi),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdo(ram_rdo)
  );

  always #5 clk = ~clk;

  // Read-first BRAM with registered output.
  always @(posedge clk) begin
    if (ram_re === 1'b1) ram_rdo <= mem[ram_raddr];
    if (ram_we === 1'b1) mem[ram_waddr] <= ram_wdi;
    if (ram_we === 1'b1) we_count <= we_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic exp_we, input logic [11:0] exp_idx,
                          input logic [1:0] exp_resp, input string tag);
    int wc0;
    wc0 = we_count;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    checks++; if (awready !== 1'b1 || wready !== 1'b1) begin errors++; $display("FAIL %s ready: aw=%b w=%b exp 1 1", tag, awready, wready); end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++; if (ram_we !== exp_we) begin errors++; $display("FAIL %s ram_we: got %b exp %b", tag, ram_we, exp_we); end
    if (exp_we) begin
      checks++; if (ram_waddr !== exp_idx || ram_wdi !== d) begin errors++; $display("FAIL %s wport: got %h/%h exp %h/%h", tag, ram_waddr, ram_wdi, exp_idx, d); end
    end
    checks++; if (bvalid !== 1'b0 || awready !== 1'b0 || wready !== 1'b0) begin errors++; $display("FAIL %s mem-phase: bvalid=%b aw=%b w=%b exp 0 0 0", tag, bvalid, awready, wready); end
    tick();
    checks++; if (bvalid !== 1'b1 || bresp !== exp_resp || ram_we !== 1'b0) begin errors++; $display("FAIL %s bresp: bvalid=%b bresp=%b we=%b exp 1 %b 0", tag, bvalid, bresp, ram_we, exp_resp); end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++; if (bvalid !== 1'b0 || awready !== 1'b1) begin errors++; $display("FAIL %s b-done: bvalid=%b awready=%b exp 0 1", tag, bvalid, awready); end
    checks++; if (we_count - wc0 !== int'(exp_we)) begin errors++; $display("FAIL %s we_pulses: got %0d exp %0d", tag, we_count - wc0, exp_we); end
  endtask

  task automatic do_read(input logic [11:0] a, input logic [31:0] d, input logic ok,
                         input logic [11:0] exp_idx, input string tag);
    logic        ere;
    logic [31:0] ed;
    logic [1:0]  er;
    ere = RB & ok;
    ed  = ere ? d : 32'h0;
    er  = ere ? 2'b00 : 2'b10;
    araddr = a; arvalid = 1'b1;
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL %s arready: got %b exp 1", tag, arready); end
    tick();
    arvalid = 1'b0;
    checks++; if (ram_re !== ere || rvalid !== 1'b0 || arready !== 1'b0) begin errors++; $display("FAIL %s r-mem: re=%b rvalid=%b ar=%b exp %b 0 0", tag, ram_re, rvalid, arready, ere); end
    if (ere) begin
      checks++; if (ram_raddr !== exp_idx) begin errors++; $display("FAIL %s raddr: got %h exp %h", tag, ram_raddr, exp_idx); end
    end
    tick();
    checks++; if (rvalid !== 1'b1 || rdata !== ed || rresp !== er) begin errors++; $display("FAIL %s rdata: rvalid=%b rdata=%h rresp=%b exp 1 %h %b", tag, rvalid, rdata, rresp, ed, er); end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin errors++; $display("FAIL %s r-done: rvalid=%b arready=%b exp 0 1", tag, rvalid, arready); end
  endtask

  task automatic test_reset();
    tick();
    checks++; if ({awready, wready, arready, bvalid, rvalid, ram_we, ram_re} !== 7'b0) begin errors++; $display("FAIL reset_ctrl: got %b exp 0", {awready, wready, arready, bvalid, rvalid, ram_we, ram_re}); end
    checks++; if ({bresp, rresp, rdata, ram_waddr, ram_raddr, ram_wdi} !== '0) begin errors++; $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h wa=%h ra=%h wdi=%h exp 0", bresp, rresp, rdata, ram_waddr, ram_raddr, ram_wdi); end
    rst_n = 1'b1;
    #1;
    checks++; if ({awready, wready, arready} !== 3'b000) begin errors++; $display("FAIL ready_before_edge: got %b exp 000", {awready, wready, arready}); end
    tick();
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL ready_first_edge: got %b exp 111", {awready, wready, arready}); end
  endtask

  task automatic test_basic();
    do_write(12'h020, 32'h0000_1234, 4'hF, 1'b1, 12'd0, 2'b00, "wr_idx0");
    do_write(12'h048, 32'hDEAD_BEEF, 4'hF, 1'b1, 12'd10, 2'b00, "wr_idx10");
    do_read(12'h020, 32'h0000_1234, 1'b1, 12'd0, "rd_idx0");
    do_read(12'h048, 32'hDEAD_BEEF, 1'b1, 12'd10, "rd_idx10");
    do_read(12'h04B, 32'hDEAD_BEEF, 1'b1, 12'd10, "rd_lowbits");
  endtask

  task automatic test_order();
    // W first, AW three cycles later
    wdata = 32'hA5A5_A5A5; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    checks++; if (wready !== 1'b0 || awready !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL w_first_latched: w=%b aw=%b we=%b exp 0 1 0", wready, awready, ram_we); end
    tick(); tick();
    checks++; if (awready !== 1'b1 || bvalid !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL w_first_wait: aw=%b bvalid=%b we=%b exp 1 0 0", awready, bvalid, ram_we); end
    awaddr = 12'h024; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checks++; if (ram_we !== 1'b1 || ram_waddr !== 12'd1 || ram_wdi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL w_first_we: we=%b wa=%h wdi=%h exp 1 001 a5a5a5a5", ram_we, ram_waddr, ram_wdi); end
    tick();
    checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("FAIL w_first_b: bvalid=%b bresp=%b exp 1 00", bvalid, bresp); end
    bready = 1'b1; tick(); bready = 1'b0;
    // AW first, W three cycles later
    awaddr = 12'h024; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checks++; if (awready !== 1'b0 || wready !== 1'b1) begin errors++; $display("FAIL aw_first_latched: aw=%b w=%b exp 0 1", awready, wready); end
    tick(); tick();
    checks++; if (ram_we !== 1'b0 || bvalid !== 1'b0) begin errors++; $display("FAIL aw_first_wait: we=%b bvalid=%b exp 0 0", ram_we, bvalid); end
    wdata = 32'h5A5A_5A5A; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    checks++; if (ram_we !== 1'b1 || ram_waddr !== 12'd1 || ram_wdi !== 32'h5A5A_5A5A) begin errors++; $display("FAIL aw_first_we: we=%b wa=%h wdi=%h exp 1 001 5a5a5a5a", ram_we, ram_waddr, ram_wdi); end
    tick();
    checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("FAIL aw_first_b: bvalid=%b bresp=%b exp 1 00", bvalid, bresp); end
    bready = 1'b1; tick(); bready = 1'b0;
    do_read(12'h024, 32'h5A5A_5A5A, 1'b1, 12'd1, "rd_idx1");
  endtask

  task automatic test_errors();
    do_write(12'h04C, 32'h1357_9BDF, 4'hF, 1'b0, 12'd11, 2'b10, "wr_past_end");
    do_write(12'h01C, 32'h2468_ACE0, 4'hF, 1'b0, 12'd0, 2'b10, "wr_below_base");
    do_write(12'h038, 32'hFFFF_FFFF, 4'h3, 1'b0, 12'd6, 2'b10, "wr_partial_strb");
    do_read(12'h04C, 32'h0, 1'b0, 12'd11, "rd_past_end");
    do_read(12'h01C, 32'h0, 1'b0, 12'd0, "rd_below_base");
    do_read(12'h038, 32'h0, 1'b1, 12'd6, "rd_after_partial");
  endtask

  task automatic test_stall();
    awaddr = 12'h02C; wdata = 32'h3333_3333; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awaddr = 12'h030; wdata = 32'h4444_4444;  // next write waits behind the stall
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL b_stall%0d: bvalid=%b bresp=%b aw=%b w=%b we=%b exp 1 00 0 0 0", i, bvalid, bresp, awready, wready, ram_we); end
    end
    bready = 1'b1; tick(); bready = 1'b0;
    checks++; if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin errors++; $display("FAIL b_release: bvalid=%b aw=%b w=%b exp 0 1 1", bvalid, awready, wready); end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++; if (ram_we !== 1'b1 || ram_waddr !== 12'd4 || ram_wdi !== 32'h4444_4444) begin errors++; $display("FAIL b_next_we: we=%b wa=%h wdi=%h exp 1 004 44444444", ram_we, ram_waddr, ram_wdi); end
    tick();
    bready = 1'b1; tick(); bready = 1'b0;
    // read side stall
    araddr = 12'h02C; arvalid = 1'b1;
    tick();
    araddr = 12'h030;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (rvalid !== 1'b1 || rdata !== (RB ? 32'h3333_3333 : 32'h0) || rresp !== (RB ? 2'b00 : 2'b10) || arready !== 1'b0 || ram_re !== 1'b0) begin errors++; $display("FAIL r_stall%0d: rvalid=%b rdata=%h rresp=%b ar=%b re=%b", i, rvalid, rdata, rresp, arready, ram_re); end
    end
    rready = 1'b1; tick(); rready = 1'b0;
    checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin errors++; $display("FAIL r_release: rvalid=%b ar=%b exp 0 1", rvalid, arready); end
    tick();
    arvalid = 1'b0;
    checks++; if (ram_re !== RB || (RB && ram_raddr !== 12'd4)) begin errors++; $display("FAIL r_next_re: re=%b ra=%h exp %b 004", ram_re, ram_raddr, RB); end
    tick();
    checks++; if (rvalid !== 1'b1 || rdata !== (RB ? 32'h4444_4444 : 32'h0)) begin errors++; $display("FAIL r_next_data: rvalid=%b rdata=%h", rvalid, rdata); end
    rready = 1'b1; tick(); rready = 1'b0;
  endtask

  task automatic test_concurrent();
    do_write(12'h028, 32'h2222_2222, 4'hF, 1'b1, 12'd2, 2'b00, "wr_idx2_old");
    awaddr = 12'h028; wdata = 32'h1111_1111; wstrb = 4'hF; araddr = 12'h028;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++; if (ram_we !== 1'b1 || ram_re !== RB) begin errors++; $display("FAIL conc_ports: we=%b re=%b exp 1 %b", ram_we, ram_re, RB); end
    tick();
    checks++; if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== (RB ? 32'h2222_2222 : 32'h0)) begin errors++; $display("FAIL conc_old_data: bvalid=%b rvalid=%b rdata=%h", bvalid, rvalid, rdata); end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    do_read(12'h028, 32'h1111_1111, 1'b1, 12'd2, "rd_idx2_new");
  endtask

  task automatic test_reset_mid();
    int wc0;
    wc0 = we_count;
    awaddr = 12'h034; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checks++; if (awready !== 1'b0 || wready !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: aw=%b w=%b exp 0 1", awready, wready); end
    rst_n = 1'b0;
    #1;
    checks++; if ({awready, wready, arready, bvalid, rvalid, ram_we, ram_re} !== 7'b0 || ram_waddr !== '0 || ram_wdi !== '0) begin errors++; $display("FAIL rst_mid_async: ctrl=%b wa=%h wdi=%h exp 0", {awready, wready, arready, bvalid, rvalid, ram_we, ram_re}, ram_waddr, ram_wdi); end
    wdata = 32'hBAD0_BAD0; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (awready !== 1'b1 || wready !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: aw=%b w=%b we=%b exp 1 1 0", awready, wready, ram_we); end
    tick(); tick();
    checks++; if (we_count !== wc0 || bvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_we: pulses=%0d bvalid=%b exp 0 0", we_count - wc0, bvalid); end
    do_write(12'h034, 32'h5555_5555, 4'hF, 1'b1, 12'd5, 2'b00, "wr_after_rst");
    do_read(12'h034, 32'h5555_5555, 1'b1, 12'd5, "rd_after_rst");
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    test_reset();
    test_basic();
    test_order();
    test_errors();
    test_stall();
    test_concurrent();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
